// File: rtl/assert_pkg.sv
// rtl/assert_pkg.sv - shared types and limits for the assertion report arbiter
package assert_pkg;
  typedef enum logic {IDLE, PRESENT} state_t;

  localparam int NUM_CHK_MAX = 32;
  localparam int TS_W_MAX    = 32;

  typedef struct packed {
    logic [$clog2(NUM_CHK_MAX)-1:0] id;
    logic                           lost;
    logic [TS_W_MAX-1:0]            ts;
  } report_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority encoder
// Searches req from ptr+1 upward, wrapping modulo N.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] grant,
  output logic            any
);
  int idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/assert_report_arbiter.sv
// rtl/assert_report_arbiter.sv - sticky checker-failure latch with round-robin report stream
// Optional capture timestamps are compiled in with ASSERT_TS_EN.
module assert_report_arbiter
  import assert_pkg::*;
#(
  parameter int NUM_CHK = 4,
  parameter int CNT_W   = 8,
  parameter int TS_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               clear,
  input  logic [NUM_CHK-1:0] chk_fire,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [$clog2(NUM_CHK)-1:0] report_id,
  output logic               report_lost,
`ifdef ASSERT_TS_EN
  output logic [TS_W-1:0]    report_ts,
`endif
  output logic               any_fail,
  output logic [CNT_W-1:0]   fail_count
);
  localparam int ID_W = $clog2(NUM_CHK);

  state_t             state;
  logic [NUM_CHK-1:0] pending, lost;
  logic [NUM_CHK-1:0] fire_eff, base_pend, base_lost, pend_nxt, lost_nxt;
  logic [ID_W-1:0]    ptr, pick_id;
  logic               pick_any, do_grant;
  logic [5:0]         pop;
  logic [CNT_W+5:0]   sum;
  logic [CNT_W-1:0]   cnt_nxt;

  rr_pick #(.N(NUM_CHK), .ID_W(ID_W)) u_pick (
    .req   (pending),
    .ptr   (ptr),
    .grant (pick_id),
    .any   (pick_any)
  );

  // clear wipes prior state first; same-cycle fires then latch on top as fresh events
  always_comb begin
    fire_eff  = chk_fire & {NUM_CHK{enable}};
    base_pend = clear ? '0 : pending;
    base_lost = clear ? '0 : lost;
    do_grant  = (state == IDLE) && pick_any && !clear;
    if (do_grant) begin
      base_pend[pick_id] = 1'b0;
      base_lost[pick_id] = 1'b0;
    end
    pend_nxt = base_pend | fire_eff;
    lost_nxt = base_lost | (base_pend & fire_eff);
    pop = '0;
    for (int i = 0; i < NUM_CHK; i++) pop = pop + 6'(fire_eff[i]);
    sum = (CNT_W+6)'(clear ? '0 : fail_count) + (CNT_W+6)'(pop);
    cnt_nxt = (|sum[CNT_W+5:CNT_W]) ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pending      <= '0;
      lost         <= '0;
      ptr          <= ID_W'(NUM_CHK - 1);
      report_valid <= 1'b0;
      report_id    <= '0;
      report_lost  <= 1'b0;
      any_fail     <= 1'b0;
      fail_count   <= '0;
    end else begin
      pending    <= pend_nxt;
      lost       <= lost_nxt;
      fail_count <= cnt_nxt;
      any_fail   <= (any_fail && !clear) || (|fire_eff);
      case (state)
        IDLE: if (do_grant) begin
          report_id    <= pick_id;
          report_lost  <= lost[pick_id];
          ptr          <= pick_id;
          report_valid <= 1'b1;
          state        <= PRESENT;
        end
        PRESENT: if (report_ready) begin
          report_valid <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ASSERT_TS_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_q [NUM_CHK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt    <= '0;
      report_ts <= '0;
      for (int i = 0; i < NUM_CHK; i++) ts_q[i] <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      for (int i = 0; i < NUM_CHK; i++)
        if (fire_eff[i] && !base_pend[i]) ts_q[i] <= ts_cnt;
      if (do_grant) report_ts <= ts_q[pick_id];
    end
  end
`endif
endmodule

// File: tb/tb_assert_report_arbiter.sv
// tb/tb_assert_report_arbiter.sv - directed self-checking bench for assert_report_arbiter
module tb_assert_report_arbiter;
  localparam int NUM_CHK = 4;
  localparam int CNT_W   = 4;
  localparam int TS_W    = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic               clear;
  logic [NUM_CHK-1:0] chk_fire;
  logic               report_valid;
  logic               report_ready;
  logic [1:0]         report_id;
  logic               report_lost;
`ifdef ASSERT_TS_EN
  logic [TS_W-1:0]    report_ts;
`endif
  logic               any_fail;
  logic [CNT_W-1:0]   fail_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  assert_report_arbiter #(.NUM_CHK(NUM_CHK), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .clear        (clear),
    .chk_fire     (chk_fire),
    .report_valid (report_valid),
    .report_ready (report_ready),
    .report_id    (report_id),
    .report_lost  (report_lost),
`ifdef ASSERT_TS_EN
    .report_ts    (report_ts),
`endif
    .any_fail     (any_fail),
    .fail_count   (fail_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  // cycle 0 is the cycle right after release; the timestamp counter reads cyc
  task automatic do_reset;
    rst_n = 1'b0;
    chk_fire = '0;
    clear = 1'b0;
    enable = 1'b1;
    report_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    clear = 1'b0;
    chk_fire = '0;
    report_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_valid", 32'(report_valid), 0);
    check("rst_id", 32'(report_id), 0);
    check("rst_lost", 32'(report_lost), 0);
    check("rst_any", 32'(any_fail), 0);
    check("rst_cnt", 32'(fail_count), 0);

    // single fire of checker 2 in cycle 5
    do_reset();
    report_ready = 1'b1;
    go_to(5);
    chk_fire = 4'b0100;
    tick();
    chk_fire = '0;
    check("t1_valid_c6", 32'(report_valid), 0);
    check("t1_any", 32'(any_fail), 1);
    check("t1_cnt", 32'(fail_count), 1);
    tick();
    check("t1_valid_c7", 32'(report_valid), 1);
    check("t1_id", 32'(report_id), 2);
    check("t1_lost", 32'(report_lost), 0);
`ifdef ASSERT_TS_EN
    check("t1_ts", 32'(report_ts), 5);
`endif
    tick();
    check("t1_drop", 32'(report_valid), 0);

    // all four fire together: reports 0,1,2,3 every other cycle
    do_reset();
    report_ready = 1'b1;
    go_to(3);
    chk_fire = 4'hF;
    tick();
    chk_fire = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t2_valid", 32'(report_valid), 1);
      check("t2_id", 32'(report_id), 32'(k));
      tick();
      check("t2_gap", 32'(report_valid), 0);
      tick();
    end
    check("t2_cnt", 32'(fail_count), 4);

    // checker 1 fires three times while another report is held
    do_reset();
    go_to(1);
    chk_fire = 4'b0001;
    tick();
    chk_fire = '0;
    tick();
    check("t3_first_valid", 32'(report_valid), 1);
    check("t3_first_id", 32'(report_id), 0);
    chk_fire = 4'b0010;
    go_to(6);
    chk_fire = '0;
    go_to(10);
    report_ready = 1'b1;
    tick();
    check("t3_gap", 32'(report_valid), 0);
    tick();
    check("t3_valid", 32'(report_valid), 1);
    check("t3_id", 32'(report_id), 1);
    check("t3_lost", 32'(report_lost), 1);
`ifdef ASSERT_TS_EN
    check("t3_ts", 32'(report_ts), 3);
`endif
    check("t3_cnt", 32'(fail_count), 4);
    go_to(17);
    check("t3_no_second", 32'(report_valid), 0);

    // ready low for 20 cycles, then round-robin continues after id 1
    do_reset();
    go_to(1);
    chk_fire = 4'b0010;
    tick();
    chk_fire = '0;
    tick();
    chk_fire = 4'b0101;
    for (int j = 0; j < 20; j++) begin
      check("t4_hold_valid", 32'(report_valid), 1);
      check("t4_hold_id", 32'(report_id), 1);
      check("t4_hold_lost", 32'(report_lost), 0);
      if (j < 19) tick();
      chk_fire = '0;
    end
    report_ready = 1'b1;
    tick();
    check("t4_gap", 32'(report_valid), 0);
    tick();
    check("t4_next_id", 32'(report_id), 2);
    check("t4_next_valid", 32'(report_valid), 1);
    tick();
    tick();
    check("t4_last_id", 32'(report_id), 0);
    check("t4_last_valid", 32'(report_valid), 1);

    // 20 fires saturate a 4-bit counter; clear with and without a fire
    do_reset();
    report_ready = 1'b1;
    go_to(1);
    chk_fire = 4'hF;
    tick(); tick(); tick();
    check("t5_cnt12", 32'(fail_count), 12);
    tick(); tick();
    chk_fire = '0;
    check("t5_sat", 32'(fail_count), 15);
    clear = 1'b1;
    chk_fire = 4'b0001;
    tick();
    chk_fire = '0;
    check("t5_clr_fire_cnt", 32'(fail_count), 1);
    check("t5_clr_fire_any", 32'(any_fail), 1);
    tick();
    clear = 1'b0;
    check("t5_clr_cnt", 32'(fail_count), 0);
    check("t5_clr_any", 32'(any_fail), 0);

    // reset while presenting abandons the report and restarts search at 0
    do_reset();
    go_to(1);
    chk_fire = 4'b0100;
    tick();
    chk_fire = '0;
    tick();
    check("t6_pre_valid", 32'(report_valid), 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(report_valid), 0);
    check("t6_async_any", 32'(any_fail), 0);
    check("t6_async_cnt", 32'(fail_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;
    report_ready = 1'b1;
    tick();
    check("t6_no_stale", 32'(report_valid), 0);
    chk_fire = 4'b1001;
    tick();
    chk_fire = '0;
    tick();
    check("t6_first_id", 32'(report_id), 0);
    check("t6_first_valid", 32'(report_valid), 1);
    tick();
    tick();
    check("t6_second_id", 32'(report_id), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
